// File: rtl/mux2x1_rr_arbiter.sv
// mux2x1_rr_arbiter: round-robin owner of a 2:1 stream mux.
// It holds a grant per packet and bounds the burst length while the other side waits.
module mux2x1_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             last0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             last1,
    output logic             gnt1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_sel, w_sel_nxt;
    logic          r_rr_last, w_rr_last_nxt;
    logic [CW-1:0] r_beat_cnt, w_beat_cnt_nxt, w_cnt_inc;
    logic          w_own, w_req_own, w_req_oth, w_last_own, w_xfer, w_release;

    assign w_own      = r_state == OWN1;
    assign w_req_own  = w_own ? req1 : req0;
    assign w_req_oth  = w_own ? req0 : req1;
    assign w_last_own = w_own ? last1 : last0;
    assign busy       = r_state != IDLE;
    assign sel        = r_sel;
    assign out_valid  = busy & w_req_own;
    assign w_xfer     = out_valid & out_ready;
    assign gnt0       = w_xfer & (r_state == OWN0);
    assign gnt1       = w_xfer & w_own;
    assign out_data   = busy ? (r_sel ? data1 : data0) : '0;
    // The count saturates so an uncontested long packet never wraps it.
    assign w_cnt_inc  = (r_beat_cnt == MAXC) ? MAXC : r_beat_cnt + 1'b1;
    assign w_release  = busy & ((w_xfer & w_last_own)
                              | (w_xfer & (w_cnt_inc == MAXC) & w_req_oth)
                              | ~w_req_own);

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_rr_last_nxt  = r_rr_last;
        w_beat_cnt_nxt = r_beat_cnt;
        if (!busy) begin
            if (req0 | req1) begin
                w_sel_nxt   = (req0 & req1) ? ~r_rr_last : req1;
                w_state_nxt = w_sel_nxt ? OWN1 : OWN0;
            end
        end else if (w_release) begin
            w_rr_last_nxt  = w_own;
            w_beat_cnt_nxt = '0;
            if (w_req_oth) begin
                w_sel_nxt   = ~w_own;
                w_state_nxt = w_own ? OWN0 : OWN1;
            end else begin
                w_state_nxt = IDLE;
            end
        end else if (w_xfer) begin
            w_beat_cnt_nxt = w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= 1'b0;
            r_rr_last  <= 1'b1;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// tb_mux2x1_rr_arbiter: directed scenarios with literal expectations, then random traffic,
// all continuously compared against a packet-level ownership model.
module tb_mux2x1_rr_arbiter;
    localparam int MAXB = 4;

    logic       clk, rst_n;
    logic       req0, last0, gnt0, req1, last1, gnt1;
    logic [7:0] data0, data1, out_data;
    logic       out_valid, out_ready, sel, busy;
    int         total = 0, bad = 0;

    mux2x1_rr_arbiter #(.WIDTH(8), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .last0(last0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .last1(last1), .gnt1(gnt1),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Model: who owns the channel (-1 none), beats served this grant, last served requester.
    int         m_own = -1, m_cnt = 0, m_last = 1;
    logic [1:0] mr;
    logic       mv, mx, ml, mo;
    logic [7:0] md;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_own = -1; m_cnt = 0; m_last = 1;
            chk("rst_valid", out_valid, 0);
            chk("rst_gnt", {gnt1, gnt0}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sel", sel, 0);
            chk("rst_data", out_data, 0);
        end else begin
            mr = {req1, req0};
            mv = (m_own >= 0) && mr[m_own];
            md = (m_own == 0) ? data0 : (m_own == 1) ? data1 : 8'h00;
            chk("m_valid", out_valid, mv);
            chk("m_gnt0", gnt0, (m_own == 0) && mv && out_ready);
            chk("m_gnt1", gnt1, (m_own == 1) && mv && out_ready);
            chk("m_busy", busy, m_own >= 0);
            chk("m_data", out_data, md);
            if (m_own >= 0) chk("m_sel", sel, m_own == 1);
            if (m_own < 0) begin
                if (mr == 2'b11) m_own = 1 - m_last;
                else if (mr != 2'b00) m_own = req1;
            end else begin
                mx = mv && out_ready;
                ml = m_own ? last1 : last0;
                mo = mr[1 - m_own];
                if (mx && m_cnt < MAXB) m_cnt++;
                if ((mx && ml) || (mx && m_cnt == MAXB && mo) || !mr[m_own]) begin
                    m_last = m_own;
                    m_cnt  = 0;
                    m_own  = mo ? 1 - m_own : -1;
                end
            end
        end
    end

    logic h0, h1, e;

    initial begin
        rst_n = 0; out_ready = 1;
        req0 = 0; data0 = 0; last0 = 0; req1 = 0; data1 = 0; last1 = 0;
        step(); step(); settle();
        chk("reset_busy", busy, 0);
        chk("reset_sel", sel, 0);
        step(); rst_n = 1;
        step();
        // single requester, three beats
        req0 = 1; data0 = 8'hA5; settle();
        chk("sr_arb_busy", busy, 0);
        chk("sr_arb_valid", out_valid, 0);
        step(); settle();
        chk("sr_b0", out_data, 8'hA5); chk("sr_g0", gnt0, 1);
        step(); data0 = 8'h3C; settle();
        chk("sr_b1", out_data, 8'h3C); chk("sr_g1", gnt0, 1);
        step(); data0 = 8'hF0; last0 = 1; settle();
        chk("sr_b2", out_data, 8'hF0); chk("sr_g2", gnt0, 1);
        step(); req0 = 0; last0 = 0; settle();
        chk("sr_done", busy, 0);
        // tie with single-beat packets: alternation, no bubble
        step(); req0 = 1; req1 = 1; last0 = 1; last1 = 1; data0 = 8'h11; data1 = 8'h22; settle();
        chk("tie_arb", busy, 0);
        e = 1;
        for (int i = 0; i < 6; i++) begin
            step(); settle();
            chk("tie_g0", gnt0, !e);
            chk("tie_g1", gnt1, e);
            chk("tie_sel", sel, e);
            chk("tie_data", out_data, e ? 8'h22 : 8'h11);
            e = !e;
        end
        step(); req0 = 0; req1 = 0; last0 = 0; last1 = 0; settle();
        chk("tie_end_valid", out_valid, 0);
        // burst limit
        step(); req0 = 1; data0 = 1; settle();
        chk("bl_arb", busy, 0);
        step(); settle();
        chk("bl_b1", out_data, 1); chk("bl_g1", gnt0, 1);
        step(); data0 = 2; req1 = 1; data1 = 8'h80; last1 = 1; settle();
        chk("bl_b2", out_data, 2); chk("bl_g2", gnt0, 1); chk("bl_no1", gnt1, 0);
        step(); data0 = 3; settle();
        chk("bl_b3", out_data, 3);
        step(); data0 = 4; settle();
        chk("bl_b4", out_data, 4); chk("bl_g4", gnt0, 1);
        step(); data0 = 5; settle();
        chk("bl_pre_g1", gnt1, 1); chk("bl_pre_g0", gnt0, 0);
        chk("bl_pre_data", out_data, 8'h80); chk("bl_pre_sel", sel, 1);
        step(); req1 = 0; last1 = 0; settle();
        chk("bl_resume", out_data, 5); chk("bl_resume_g", gnt0, 1); chk("bl_resume_sel", sel, 0);
        // backpressure: three stalled cycles
        step(); data0 = 6; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            settle();
            chk("bp_gnt", gnt0, 0); chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 6); chk("bp_busy", busy, 1);
        end
        step(); out_ready = 1; settle();
        chk("bp_go", gnt0, 1);
        step(); data0 = 7; req1 = 1; data1 = 8'h81; settle();
        chk("bp_b7", out_data, 7); chk("bp_g7", gnt0, 1);
        step(); data0 = 8; settle();
        chk("bp_b8", out_data, 8);
        step(); data0 = 9; settle();
        chk("bp_cnt_hold", gnt1, 1); chk("bp_d81", out_data, 8'h81);
        // withdrawal of the owner
        step(); req1 = 0; settle();
        chk("wd_valid", out_valid, 0); chk("wd_g", {gnt1, gnt0}, 0);
        step(); last0 = 1; settle();
        chk("wd_own0", gnt0, 1); chk("wd_sel", sel, 0); chk("wd_data", out_data, 9);
        step(); req0 = 0; last0 = 0; settle();
        chk("wd_idle", busy, 0);
        // reset in the middle of a packet
        step(); req1 = 1; data1 = 8'h44; settle();
        step(); settle();
        chk("mr_own1", gnt1, 1);
        step(); rst_n = 0; settle();
        chk("mr_g1", gnt1, 0); chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0); chk("mr_sel", sel, 0);
        step(); rst_n = 1; req0 = 1; settle();
        chk("mr_idle", busy, 0);
        step(); settle();
        chk("mr_first0", gnt0, 1); chk("mr_first_sel", sel, 0); chk("mr_no1", gnt1, 0);
        step(); req0 = 0; req1 = 0;
        step();
        // random traffic, protocol-respecting sources
        h0 = 0; h1 = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n     = ($urandom_range(0, 299) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!h0) begin data0 = 8'($urandom); last0 = ($urandom_range(0, 3) == 0); end
            if (!h1) begin data1 = 8'($urandom); last1 = ($urandom_range(0, 3) == 0); end
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            settle();
            h0 = req0 && !gnt0;
            h1 = req1 && !gnt1;
        end
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
